// File: rtl/axis_frame_pkg.sv
// Shared types for the AXI-Stream frame buffer: FSM state encoding and strobe-width helper.
package axis_frame_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WRITE,
        S_DRAIN,
        S_STORED,
        S_READ
    } fb_state_t;

    function automatic int strb_width(input int data_width);
        return data_width / 8;
    endfunction

endpackage

// File: rtl/axis_fb_ram.sv
// Frame storage: one byte-enabled write port and one registered read port.
// rd_data only changes on a cycle with rd_en, so it can be held as a pipeline stage.
module axis_fb_ram
    import axis_frame_pkg::*;
#(
    parameter  int DATA_WIDTH = 32,
    parameter  int DEPTH      = 16,
    localparam int ADDR_W     = $clog2(DEPTH),
    localparam int STRB_W     = strb_width(DATA_WIDTH)
) (
    input  logic                  clk,
    input  logic                  wr_en,
    input  logic [ADDR_W-1:0]     wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic [STRB_W-1:0]     wr_strb,
    input  logic                  rd_en,
    input  logic [ADDR_W-1:0]     rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data
);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [DATA_WIDTH-1:0] rd_data_q;

    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int b = 0; b < STRB_W; b++) begin
                if (wr_strb[b]) begin
                    mem_q[wr_addr][b*8 +: 8] <= wr_data[b*8 +: 8];
                end
            end
        end
        if (rd_en) begin
            rd_data_q <= mem_q[rd_addr];
        end
    end

    assign rd_data = rd_data_q;

endmodule

// File: rtl/axis_frame_buffer.sv
// Stores one AXI-Stream frame from s01 into a byte-enabled RAM and replays it on m01.
// Define AXIS_FRAME_REPLAY_EN to keep the frame after readout and add the frame_release input.
module axis_frame_buffer
    import axis_frame_pkg::*;
#(
    parameter  int DATA_WIDTH = 32,
    parameter  int DEPTH      = 16,
    localparam int ADDR_W     = $clog2(DEPTH),
    localparam int STRB_W     = strb_width(DATA_WIDTH)
) (
    input  logic                  s01_axis_aclk,
    input  logic                  s01_axis_aresetn,
    input  logic [DATA_WIDTH-1:0] s01_axis_tdata,
    input  logic [STRB_W-1:0]     s01_axis_tstrb,
    input  logic                  s01_axis_tvalid,
    input  logic                  s01_axis_tlast,
    output logic                  s01_axis_tready,
    input  logic                  rd_start,
`ifdef AXIS_FRAME_REPLAY_EN
    input  logic                  frame_release,
`endif
    input  logic                  m01_axis_tready,
    output logic [DATA_WIDTH-1:0] m01_axis_tdata,
    output logic [STRB_W-1:0]     m01_axis_tstrb,
    output logic                  m01_axis_tvalid,
    output logic                  m01_axis_tlast,
    output logic                  frame_ready,
    output logic [ADDR_W:0]       frame_len,
    output logic                  overflow
);

    localparam logic [ADDR_W:0] PTR_ONE  = (ADDR_W+1)'(1);
    localparam logic [ADDR_W:0] PTR_LAST = (ADDR_W+1)'(DEPTH - 1);

    fb_state_t             state_q, state_d;
    logic [ADDR_W:0]       wr_ptr_q, wr_ptr_d;
    logic [ADDR_W:0]       rd_ptr_q, rd_ptr_d;
    logic                  overflow_q, overflow_d;
    logic                  tready_q, tready_d;
    logic                  frame_ready_q, frame_ready_d;
    logic                  ram_vld_q, ram_vld_d;
    logic                  ram_last_q, ram_last_d;
    logic                  out_valid_q, out_valid_d;
    logic                  out_last_q, out_last_d;
    logic [DATA_WIDTH-1:0] out_data_q, out_data_d;

    logic                  wr_en, rd_en;
    logic [ADDR_W-1:0]     wr_addr, rd_addr;
    logic [DATA_WIDTH-1:0] ram_rd_data;
    logic                  s_hs, m_hs, out_free, load_out;

    axis_fb_ram #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH)
    ) u_ram (
        .clk     (s01_axis_aclk),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data (s01_axis_tdata),
        .wr_strb (s01_axis_tstrb),
        .rd_en   (rd_en),
        .rd_addr (rd_addr),
        .rd_data (ram_rd_data)
    );

    // Both ports: a beat moves on the edge where tvalid && tready; the sender holds
    // tdata/tstrb/tlast stable and never drops tvalid until that edge.
    always_comb begin
        state_d     = state_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        overflow_d  = overflow_q;
        ram_vld_d   = ram_vld_q;
        ram_last_d  = ram_last_q;
        out_valid_d = out_valid_q;
        out_last_d  = out_last_q;
        out_data_d  = out_data_q;
        wr_en       = 1'b0;
        wr_addr     = wr_ptr_q[ADDR_W-1:0];
        rd_en       = 1'b0;
        rd_addr     = rd_ptr_q[ADDR_W-1:0];

        s_hs     = s01_axis_tvalid && tready_q;
        m_hs     = out_valid_q && m01_axis_tready;
        out_free = !out_valid_q || m01_axis_tready;
        load_out = ram_vld_q && out_free;

        case (state_q)
            S_IDLE: begin
                if (s_hs) begin
                    wr_en      = 1'b1;
                    wr_addr    = '0;
                    wr_ptr_d   = PTR_ONE;
                    overflow_d = 1'b0;
                    state_d    = s01_axis_tlast ? S_STORED : S_WRITE;
                end
            end
            S_WRITE: begin
                if (s_hs) begin
                    wr_en    = 1'b1;
                    wr_ptr_d = wr_ptr_q + PTR_ONE;
                    if (s01_axis_tlast) begin
                        state_d = S_STORED;
                    end else if (wr_ptr_q == PTR_LAST) begin
                        state_d    = S_DRAIN;
                        overflow_d = 1'b1;
                    end
                end
            end
            S_DRAIN: begin
                if (s_hs && s01_axis_tlast) begin
                    state_d = S_STORED;
                end
            end
            S_STORED: begin
`ifdef AXIS_FRAME_REPLAY_EN
                if (frame_release) begin
                    state_d  = S_IDLE;
                    wr_ptr_d = '0;
                end else
`endif
                if (rd_start) begin
                    // Issue word 0 now so the first beat is out two cycles later.
                    state_d    = S_READ;
                    rd_en      = 1'b1;
                    rd_addr    = '0;
                    rd_ptr_d   = PTR_ONE;
                    ram_vld_d  = 1'b1;
                    ram_last_d = (wr_ptr_q == PTR_ONE);
                end
            end
            S_READ: begin
                if (load_out) begin
                    out_valid_d = 1'b1;
                    out_last_d  = ram_last_q;
                    out_data_d  = ram_rd_data;
                end else if (m_hs) begin
                    out_valid_d = 1'b0;
                    out_last_d  = 1'b0;
                end
                ram_vld_d = ram_vld_q && !load_out;
                // Prefetch only when the RAM stage is empty or draining this cycle.
                if ((!ram_vld_q || load_out) && (rd_ptr_q != wr_ptr_q)) begin
                    rd_en      = 1'b1;
                    rd_ptr_d   = rd_ptr_q + PTR_ONE;
                    ram_vld_d  = 1'b1;
                    ram_last_d = ((rd_ptr_q + PTR_ONE) == wr_ptr_q);
                end
                if (m_hs && out_last_q) begin
                    out_valid_d = 1'b0;
                    out_last_d  = 1'b0;
                    rd_ptr_d    = '0;
                    ram_vld_d   = 1'b0;
                    ram_last_d  = 1'b0;
`ifdef AXIS_FRAME_REPLAY_EN
                    state_d     = S_STORED;
`else
                    state_d     = S_IDLE;
                    wr_ptr_d    = '0;
`endif
                end
            end
            default: state_d = S_IDLE;
        endcase

        tready_d      = (state_d == S_IDLE) || (state_d == S_WRITE) || (state_d == S_DRAIN);
        frame_ready_d = (state_d == S_STORED) || (state_d == S_READ);
    end

    always_ff @(posedge s01_axis_aclk or negedge s01_axis_aresetn) begin
        if (!s01_axis_aresetn) begin
            state_q       <= S_IDLE;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            overflow_q    <= 1'b0;
            tready_q      <= 1'b0;
            frame_ready_q <= 1'b0;
            ram_vld_q     <= 1'b0;
            ram_last_q    <= 1'b0;
            out_valid_q   <= 1'b0;
            out_last_q    <= 1'b0;
            out_data_q    <= '0;
        end else begin
            state_q       <= state_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            overflow_q    <= overflow_d;
            tready_q      <= tready_d;
            frame_ready_q <= frame_ready_d;
            ram_vld_q     <= ram_vld_d;
            ram_last_q    <= ram_last_d;
            out_valid_q   <= out_valid_d;
            out_last_q    <= out_last_d;
            out_data_q    <= out_data_d;
        end
    end

    assign s01_axis_tready = tready_q;
    assign m01_axis_tdata  = out_data_q;
    assign m01_axis_tstrb  = {STRB_W{out_valid_q}};
    assign m01_axis_tvalid = out_valid_q;
    assign m01_axis_tlast  = out_last_q;
    assign frame_ready     = frame_ready_q;
    assign frame_len       = wr_ptr_q;
    assign overflow        = overflow_q;

endmodule

// File: tb/tb_axis_frame_buffer.sv
// Bench for axis_frame_buffer: vector table, reset/ignore corner sequences, random frames
// checked against a byte-level memory model. Honours AXIS_FRAME_REPLAY_EN when defined.
module tb_axis_frame_buffer;

    localparam int DW    = 32;
    localparam int DEPTH = 16;
    localparam int SW    = DW / 8;
    localparam int AW    = $clog2(DEPTH);

    logic          clk = 1'b0;
    logic          rst_n;
    logic [DW-1:0] s_tdata;
    logic [SW-1:0] s_tstrb;
    logic          s_tvalid, s_tlast, s_tready;
    logic          rd_start;
    logic          m_tready;
    logic [DW-1:0] m_tdata;
    logic [SW-1:0] m_tstrb;
    logic          m_tvalid, m_tlast;
    logic          frame_ready;
    logic [AW:0]   frame_len;
    logic          overflow;
`ifdef AXIS_FRAME_REPLAY_EN
    logic          frame_release;
`endif

    axis_frame_buffer #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
        .s01_axis_aclk    (clk),
        .s01_axis_aresetn (rst_n),
        .s01_axis_tdata   (s_tdata),
        .s01_axis_tstrb   (s_tstrb),
        .s01_axis_tvalid  (s_tvalid),
        .s01_axis_tlast   (s_tlast),
        .s01_axis_tready  (s_tready),
        .rd_start         (rd_start),
`ifdef AXIS_FRAME_REPLAY_EN
        .frame_release    (frame_release),
`endif
        .m01_axis_tready  (m_tready),
        .m01_axis_tdata   (m_tdata),
        .m01_axis_tstrb   (m_tstrb),
        .m01_axis_tvalid  (m_tvalid),
        .m01_axis_tlast   (m_tlast),
        .frame_ready      (frame_ready),
        .frame_len        (frame_len),
        .overflow         (overflow)
    );

    // ---------------- clock / watchdog ----------------
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: got no end of test, expected finish before 1ms");
        $fatal(1, "watchdog expired");
    end

    // ---------------- scoreboard / model state ----------------
    int            n_checks = 0;
    int            n_fail   = 0;
    logic [DW-1:0] mem_m [DEPTH];
    logic [DW-1:0] exp_q [$];
    int            exp_len;
    bit            exp_ovf;
    logic [DW-1:0] first_word;

    typedef struct {
        int          n;
        logic [31:0] base;
        logic [3:0]  strb;
        int          mode;
        int          exp_len;
        bit          exp_ovf;
        logic [31:0] exp_w0;
    } vec_t;

    vec_t vecs [9];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic timeout_fail(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s: got timeout expected handshake", name);
    endtask

    // ---------------- driver tasks (entered and left at posedge+1) ----------------
    task automatic put_beat(input logic [DW-1:0] d, input logic [SW-1:0] s, input logic l);
        int waited;
        waited   = 0;
        s_tdata  = d;
        s_tstrb  = s;
        s_tlast  = l;
        s_tvalid = 1'b1;
        @(negedge clk);
        while (!s_tready && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        if (!s_tready) timeout_fail("s01_tready_wait");
        @(posedge clk);
        #1;
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
    endtask

    // Model: beat i lands in word i under its strobes; beats past DEPTH are dropped.
    task automatic send_beats(input int n, input logic [DW-1:0] base, input logic [SW-1:0] strb,
                              input bit rnd, input bit with_last);
        logic [DW-1:0] d;
        logic [SW-1:0] s;
        for (int i = 0; i < n; i++) begin
            d = rnd ? DW'($urandom) : base + DW'(i);
            s = rnd ? SW'($urandom_range(0, 15)) : strb;
            if (i < DEPTH) begin
                for (int b = 0; b < SW; b++) begin
                    if (s[b]) mem_m[i][b*8 +: 8] = d[b*8 +: 8];
                end
            end
            put_beat(d, s, with_last && (i == n - 1));
        end
        exp_len = (n > DEPTH) ? DEPTH : n;
        exp_ovf = (n > DEPTH);
    endtask

    task automatic check_stored(input string tag);
        check({tag, "_frame_ready"}, 64'(frame_ready), 64'(1));
        check({tag, "_frame_len"}, 64'(frame_len), 64'(exp_len));
        check({tag, "_overflow"}, 64'(overflow), 64'(exp_ovf));
        check({tag, "_s01_tready"}, 64'(s_tready), 64'(0));
    endtask

    task automatic pulse_rd_start();
        rd_start = 1'b1;
        @(posedge clk);
        #1;
        rd_start = 1'b0;
    endtask

    // mode 0: always ready, 1: ready toggles 1010..., 2: random ready
    task automatic read_frame(input int mode);
        int            cyc;
        int            lat;
        bit            tog;
        bit            stalled;
        bit            got_first;
        logic [DW-1:0] held;
        logic [DW-1:0] want;
        for (int i = 0; i < exp_len; i++) exp_q.push_back(mem_m[i]);
        pulse_rd_start();
        cyc       = 0;
        lat       = 0;
        tog       = 1'b1;
        stalled   = 1'b0;
        got_first = 1'b0;
        held      = '0;
        while (exp_q.size() > 0 && cyc < 200) begin
            case (mode)
                0:       m_tready = 1'b1;
                1:       begin m_tready = tog; tog = !tog; end
                default: m_tready = 1'($urandom_range(0, 1));
            endcase
            @(negedge clk);
            cyc++;
            if (m_tvalid && lat == 0) begin
                lat = cyc;
                check("first_tvalid_latency", 64'(cyc), 64'(2));
            end
            if (stalled) begin
                check("stall_hold_valid", 64'(m_tvalid), 64'(1));
                check("stall_hold_data", 64'(m_tdata), 64'(held));
                stalled = 1'b0;
            end
            if (m_tvalid) begin
                check("m01_tstrb", 64'(m_tstrb), 64'(4'hF));
                if (m_tready) begin
                    want = exp_q.pop_front();
                    check("m01_tdata", 64'(m_tdata), 64'(want));
                    check("m01_tlast", 64'(m_tlast), 64'(exp_q.size() == 0));
                    if (!got_first) begin
                        first_word = m_tdata;
                        got_first  = 1'b1;
                    end
                end else begin
                    stalled = 1'b1;
                    held    = m_tdata;
                end
            end
            @(posedge clk);
            #1;
        end
        m_tready = 1'b0;
        if (exp_q.size() != 0) begin
            timeout_fail("m01_readout");
            exp_q.delete();
        end
        @(negedge clk);
        check("no_extra_beat", 64'(m_tvalid), 64'(0));
        @(posedge clk);
        #1;
    endtask

    task automatic finish_frame(input int mode);
        read_frame(mode);
`ifdef AXIS_FRAME_REPLAY_EN
        check("replay_frame_kept", 64'(frame_ready), 64'(1));
        check("replay_frame_len", 64'(frame_len), 64'(exp_len));
        read_frame(0);
        frame_release = 1'b1;
        @(posedge clk);
        #1;
        frame_release = 1'b0;
        check("release_frame_ready", 64'(frame_ready), 64'(0));
        check("release_s01_tready", 64'(s_tready), 64'(1));
`else
        check("after_read_frame_ready", 64'(frame_ready), 64'(0));
        check("after_read_frame_len", 64'(frame_len), 64'(0));
        check("after_read_s01_tready", 64'(s_tready), 64'(1));
`endif
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_s01_tready"}, 64'(s_tready), 64'(0));
        check({tag, "_m01_tvalid"}, 64'(m_tvalid), 64'(0));
        check({tag, "_m01_tdata"}, 64'(m_tdata), 64'(0));
        check({tag, "_m01_tlast"}, 64'(m_tlast), 64'(0));
        check({tag, "_m01_tstrb"}, 64'(m_tstrb), 64'(0));
        check({tag, "_frame_ready"}, 64'(frame_ready), 64'(0));
        check({tag, "_frame_len"}, 64'(frame_len), 64'(0));
        check({tag, "_overflow"}, 64'(overflow), 64'(0));
    endtask

    task automatic release_reset();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("post_reset_s01_tready", 64'(s_tready), 64'(1));
        check("post_reset_frame_ready", 64'(frame_ready), 64'(0));
    endtask

    // ---------------- main sequence ----------------
    initial begin
        //            n   base           strb  mode len ovf   first word out
        vecs[0] = '{4,  32'h0000_00A0, 4'hF, 0, 4,  1'b0, 32'h0000_00A0};
        vecs[1] = '{1,  32'hDEAD_BEEF, 4'hF, 0, 1,  1'b0, 32'hDEAD_BEEF};
        vecs[2] = '{20, 32'h0000_0100, 4'hF, 0, 16, 1'b1, 32'h0000_0100};
        vecs[3] = '{6,  32'h0000_0200, 4'hF, 1, 6,  1'b0, 32'h0000_0200};
        vecs[4] = '{1,  32'h1122_3344, 4'hF, 0, 1,  1'b0, 32'h1122_3344};
        vecs[5] = '{1,  32'hAABB_CCDD, 4'h3, 0, 1,  1'b0, 32'h1122_CCDD};
        vecs[6] = '{16, 32'h0000_0300, 4'hF, 2, 16, 1'b0, 32'h0000_0300};
        vecs[7] = '{17, 32'h0000_0400, 4'hF, 0, 16, 1'b1, 32'h0000_0400};
        vecs[8] = '{3,  32'h0000_0500, 4'h0, 0, 3,  1'b0, 32'h0000_0400};

        for (int i = 0; i < DEPTH; i++) mem_m[i] = '0;
        rst_n    = 1'b0;
        s_tdata  = '0;
        s_tstrb  = '0;
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
        rd_start = 1'b0;
        m_tready = 1'b0;
`ifdef AXIS_FRAME_REPLAY_EN
        frame_release = 1'b0;
`endif
        repeat (3) @(posedge clk);
        #1;
        check_all_zero("reset");
        release_reset();

        for (int v = 0; v < 9; v++) begin
            send_beats(vecs[v].n, vecs[v].base, vecs[v].strb, 1'b0, 1'b1);
            check($sformatf("vec%0d_len", v), 64'(frame_len), 64'(vecs[v].exp_len));
            check($sformatf("vec%0d_ovf", v), 64'(overflow), 64'(vecs[v].exp_ovf));
            check_stored($sformatf("vec%0d", v));
            finish_frame(vecs[v].mode);
            check($sformatf("vec%0d_first_word", v), 64'(first_word), 64'(vecs[v].exp_w0));
        end

        // rd_start with nothing stored must be ignored
        pulse_rd_start();
        m_tready = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check("idle_rd_start_tvalid", 64'(m_tvalid), 64'(0));
            check("idle_rd_start_tready", 64'(s_tready), 64'(1));
        end
        @(posedge clk);
        #1;
        m_tready = 1'b0;
        send_beats(2, 32'h0000_0700, 4'hF, 1'b0, 1'b1);
        check_stored("after_ignore");
        finish_frame(0);

        // reset in the middle of a write
        send_beats(3, 32'h0000_0600, 4'hF, 1'b0, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        check_all_zero("mid_write_reset");
        release_reset();
        send_beats(5, 32'h0000_0800, 4'hF, 1'b0, 1'b1);
        check_stored("after_write_reset");
        finish_frame(0);

        // reset in the middle of a readout
        send_beats(8, 32'h0000_0900, 4'hF, 1'b0, 1'b1);
        check_stored("pre_read_reset");
        m_tready = 1'b1;
        pulse_rd_start();
        repeat (3) @(posedge clk);
        #2;
        check("mid_read_active", 64'(m_tvalid), 64'(1));
        rst_n = 1'b0;
        #1;
        check_all_zero("mid_read_reset");
        m_tready = 1'b0;
        release_reset();
        send_beats(3, 32'h0000_0A00, 4'hF, 1'b0, 1'b1);
        check_stored("after_read_reset");
        finish_frame(0);

        // random frames against the memory model
        for (int r = 0; r < 12; r++) begin
            send_beats(int'($urandom_range(1, 20)), '0, '0, 1'b1, 1'b1);
            check_stored($sformatf("rand%0d", r));
            finish_frame(int'($urandom_range(0, 2)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
